// File: rtl/mult_unit.sv
// Sequential shift-add unsigned multiplier (MULTU) that borrows the EX-stage ALU adder.
// Owns HI/LO; one product per WIDTH+1 cycles when starts are issued back to back.
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctl,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       o_state_dbg
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [2:0] ALU_ADD = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_load;
    logic             w_step;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_mcand;
    logic [CW-1:0]    r_count;

    // Next-state logic; start is only honoured from IDLE or DONE.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                    w_load       = 1'b1;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_count == LAST_COUNT) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_next_state = S_RUN;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // {HI,LO} shifts right one bit per step, with the ALU's 33-bit sum entering at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_mcand <= '0;
            r_count <= '0;
        end else if (w_load) begin
            r_hi    <= '0;
            r_lo    <= dataA;
            r_mcand <= dataB;
            r_count <= '0;
        end else if (w_step) begin
            {r_hi, r_lo} <= {alu_cout, alu_sum, r_lo[WIDTH-1:1]};
            r_count      <= r_count + 1'b1;
        end
    end

    // ALU operands come from registers only, so there is no input-to-output path.
    assign alu_a       = r_hi;
    assign alu_b       = r_lo[0] ? r_mcand : '0;
    assign alu_ctl     = ALU_ADD;

    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign o_state_dbg = r_state;

endmodule

// File: doc/mult_unit.md
# mult_unit

Sequential 32-bit unsigned shift-add multiplier for MULTU, sitting beside the EX-stage ALU. Owns the HI/LO product registers. It reuses the ALU datapath rather than a private adder: each iteration it drives the ALU operands with the ADD control code and consumes the ALU's 32-bit sum and carry-out. Results stay in HI/LO for the MFHI/MFLO path.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a multiply; sampled only in IDLE or DONE.
- dataA  in  WIDTH  multiplier, sampled with an accepted start.
- dataB  in  WIDTH  multiplicand, sampled with an accepted start.
- alu_a  out  WIDTH  ALU operand A; always the current HI register.
- alu_b  out  WIDTH  ALU operand B; the multiplicand register when LO[0]=1, else 0.
- alu_ctl  out  3  ALU control; constant 3'b010 (ADD).
- alu_sum  in  WIDTH  ALU adder result for alu_a+alu_b with carry-in 0.
- alu_cout  in  1  carry out of the ALU MSB slice.
- busy  out  1  high while iterating.
- done  out  1  one-cycle completion pulse.
- hi  out  WIDTH  upper product word.
- lo  out  WIDTH  lower product word.

## Operation
- State machine: IDLE, RUN, DONE.
  - IDLE, start=1 → RUN. Load mcand←dataB, HI←0, LO←dataA, count←0.
  - RUN, each cycle, with {HI,LO} treated as one 2·WIDTH register:
    - {HI,LO} ← {alu_cout, alu_sum, LO} >> 1.
    - count←count+1.
    - When count==WIDTH−1 at the edge → DONE.
  - DONE lasts exactly one cycle.
    - start=1 → RUN with the same loading as IDLE.
    - Otherwise → IDLE.
- Each RUN step adds mcand when LO[0]=1 and adds 0 otherwise, so the 33-bit {cout,sum} is always well defined.
- start in RUN is ignored. dataA/dataB changes during RUN have no effect.
- hi/lo are visible during RUN as partial products. Final values hold unchanged through DONE and IDLE until the next accepted start.
- alu_a, alu_b and alu_ctl are combinational from registers only, with no input-to-output path. alu_sum/alu_cout must settle combinationally within the same cycle.
- Arithmetic is unsigned. The product is modulo 2^(2·WIDTH), so overflow is impossible.
- count width: ceil(log2(WIDTH)) bits. It must not wrap before the DONE transition.

## Timing
- Reset values: state=IDLE, HI=0, LO=0, mcand=0, count=0, busy=0, done=0. Outputs alu_a=0, alu_b=0, alu_ctl=3'b010.
- rst has priority over start and over every state. Reset mid-RUN aborts, clears HI/LO and gives no done pulse.
- Latency: start accepted at edge E0.
  - busy=1 from E0 through E(WIDTH).
  - Iterations occur at edges E1..E(WIDTH).
  - After E(WIDTH): busy=0, done=1, and hi/lo hold the final product. This is 32 cycles after E0 for WIDTH=32.
- done is high for exactly one cycle, then low, unless a back-to-back start was accepted in DONE. In that case busy rises at that same edge and done falls.
- Throughput: one multiply per WIDTH+1 cycles with back-to-back starts.
- busy and done are never high together.

## Test plan
- 3 × 5:
  - start with dataA=3, dataB=5.
  - busy high 32 cycles; done pulses once.
  - hi=0x00000000, lo=0x0000000F.
  - alu_ctl=3'b010 throughout.
- Max operands:
  - dataA=dataB=0xFFFFFFFF.
  - hi=0xFFFFFFFE, lo=0x00000001. Exercises alu_cout=1 paths.
- Zero and identity:
  - 0×0x12345678 → hi=0, lo=0.
  - 1×0xDEADBEEF → hi=0, lo=0xDEADBEEF.
  - 0x80000000×2 → hi=0x00000001, lo=0.
- Start while busy:
  - start 7×9, then reassert start with 2×2 at cycle 10 of RUN.
  - Still completes at cycle 32 with lo=63, hi=0, and exactly one done pulse.
- Reset mid-run:
  - start 0xFFFF×0xFFFF, assert rst at cycle 15 for one cycle.
  - Next cycle: state IDLE, busy=0, hi=lo=0, no done pulse.
  - A new 4×4 then yields lo=16.
- Back-to-back:
  - Hold start high continuously with 6×7, then 0x10000×0x10000 presented during the DONE cycle.
  - First done pulse: hi=0, lo=42.
  - Second job starts in the DONE cycle and completes 32 cycles later with hi=0x00000001, lo=0.
  - hi/lo for the first job are readable during the DONE cycle.
